// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory store responder: funct3 codes,
// the store-queue entry layout and the store/load lane functions.
package dmem_pkg;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam int IDX_W  = 32'sd30;
    localparam int BYTE_W = 32'sd8;

    // idx is the word index zero-extended to IDX_W; only the low AW bits are ever set
    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [3:0]       mask;
        logic [31:0]      data;
    } store_entry_t;

    // A zero mask doubles as "not a store", so callers need no separate op check
    function automatic logic [3:0] store_mask(input logic [2:0] op, input logic [1:0] addr_lo);
        logic [3:0] m;
        m = 4'b0000;
        case (op)
            F3_SB:   m = 4'b0001 << addr_lo;
            F3_SH:   m = addr_lo[1] ? 4'b1100 : 4'b0011;
            F3_SW:   m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] op, input logic [31:0] data);
        logic [31:0] d;
        d = 32'h0000_0000;
        case (op)
            F3_SB:   d = {4{data[7:0]}};
            F3_SH:   d = {2{data[15:0]}};
            F3_SW:   d = data;
            default: d = 32'h0000_0000;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] op, input logic [1:0] addr_lo,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{addr_lo, 3'b000} +: BYTE_W];
        h = addr_lo[1] ? word[31:16] : word[15:0];
        r = 32'h0000_0000;
        case (op)
            F3_LB:   r = {{24{b[7]}}, b};
            F3_LH:   r = {{16{h[15]}}, h};
            F3_LW:   r = word;
            F3_LBU:  r = {24'h00_0000, b};
            F3_LHU:  r = {16'h0000, h};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_store_queue.sv
// Store queue: circular FIFO of lane-aligned store entries with occupancy flags,
// a sticky overflow flag, and an oldest-first view of every entry for load merging.
module dmem_store_queue
    import dmem_pkg::*;
#(
    parameter int DEPTH = 32'sd4,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_req,
    input  store_entry_t             push_entry,
    input  logic                     pop_req,
    output logic                     pop_accept,
    output logic                     push_accept,
    output store_entry_t             head_entry,
    output store_entry_t [DEPTH-1:0] ordered,
    output logic [DEPTH-1:0]         ordered_valid,
    output logic [PW:0]              count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow
);

    store_entry_t  mem_r [DEPTH];
    logic [PW-1:0] head_r;
    logic [PW-1:0] tail_r;
    logic [PW:0]   count_r;
    logic          full_r;
    logic          empty_r;
    logic          overflow_r;

    logic          do_pop_s;
    logic          do_push_s;
    logic          drop_s;
    logic [PW:0]   count_next_s;

    // Accept/drop decisions and next occupancy; a drain frees the slot a full-queue push needs
    always_comb begin
        do_pop_s     = pop_req && !empty_r;
        do_push_s    = push_req && (!full_r || do_pop_s);
        drop_s       = push_req && full_r && !do_pop_s;
        count_next_s = count_r;
        if (do_push_s && !do_pop_s) begin
            count_next_s = count_r + (PW+1)'(1);
        end else if (do_pop_s && !do_push_s) begin
            count_next_s = count_r - (PW+1)'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // Pointers, occupancy and flags; full/empty are re-decoded from the next count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r     <= '0;
            tail_r     <= '0;
            count_r    <= '0;
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            overflow_r <= 1'b0;
        end else begin
            if (do_push_s) begin
                tail_r <= tail_r + PW'(1);
            end
            if (do_pop_s) begin
                head_r <= head_r + PW'(1);
            end
            count_r <= count_next_s;
            full_r  <= (count_next_s == (PW+1)'(DEPTH));
            empty_r <= (count_next_s == (PW+1)'(0));
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Entry storage; contents need no reset because pointers and count gate validity
    always_ff @(posedge clk) begin
        if (do_push_s && !rst) begin
            mem_r[tail_r] <= push_entry;
        end
    end

    // Rotate storage so index 0 is always the oldest live entry
    always_comb begin
        ordered       = '0;
        ordered_valid = '0;
        for (int k = 32'sd0; k < DEPTH; k++) begin
            ordered[k]       = mem_r[head_r + PW'(k)];
            ordered_valid[k] = ((PW+1)'(k) < count_r);
        end
    end

    assign pop_accept  = do_pop_s;
    assign push_accept = do_push_s;
    assign head_entry  = mem_r[head_r];
    assign count       = count_r;
    assign full        = full_r;
    assign empty       = empty_r;
    assign overflow    = overflow_r;

endmodule

// File: rtl/dmem_store_responder.sv
// Data-memory responder: queued stores drain into a word RAM when no load is
// active; loads merge pending stores byte-wise. DMEM_PERF_EN adds perf counters.
module dmem_store_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH     = 32'sd4,
    parameter int MEM_WORDS = 32'sd1024,
    localparam int AW = $clog2(MEM_WORDS),
    localparam int PW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          write_en,
    input  logic [2:0]    write_op,
    input  logic [31:0]   write_addr,
    input  logic [31:0]   write_data,
    input  logic          read_en,
    input  logic [2:0]    read_op,
    input  logic [31:0]   read_addr,
    output logic [31:0]   read_data,
    output logic          sq_full,
    output logic          sq_empty,
    output logic [PW:0]   sq_count,
    output logic          overflow_err
`ifdef DMEM_PERF_EN
    ,
    output logic [31:0]   perf_stores,
    output logic [31:0]   perf_drain_stall,
    output logic [PW:0]   perf_max_occ
`endif
);

    logic [31:0]              ram_r [MEM_WORDS];

    store_entry_t             push_entry_s;
    logic [3:0]               push_mask_s;
    logic                     push_req_s;
    logic                     push_accept_s;
    logic                     pop_accept_s;
    store_entry_t             head_entry_s;
    store_entry_t [DEPTH-1:0] ordered_s;
    logic [DEPTH-1:0]         ordered_valid_s;
    logic                     ram_we_s;
    logic [AW-1:0]            ram_widx_s;
    logic [AW-1:0]            read_idx_s;
    logic [IDX_W-1:0]         read_idx_ext_s;
    logic [31:0]              raw_s;
    logic [31:0]              read_data_s;
    logic                     unused_s;

    assign push_mask_s       = store_mask(write_op, write_addr[1:0]);
    assign push_req_s        = write_en && (push_mask_s != 4'b0000);
    assign push_entry_s.idx  = IDX_W'(write_addr[AW+1:2]);
    assign push_entry_s.mask = push_mask_s;
    assign push_entry_s.data = store_lanes(write_op, write_data);

    dmem_store_queue #(
        .DEPTH (DEPTH)
    ) u_sq (
        .clk           (clk),
        .rst           (rst),
        .push_req      (push_req_s),
        .push_entry    (push_entry_s),
        .pop_req       (!read_en),
        .pop_accept    (pop_accept_s),
        .push_accept   (push_accept_s),
        .head_entry    (head_entry_s),
        .ordered       (ordered_s),
        .ordered_valid (ordered_valid_s),
        .count         (sq_count),
        .full          (sq_full),
        .empty         (sq_empty),
        .overflow      (overflow_err)
    );

    // Gating with rst keeps a drain from landing on the same edge reset is raised
    assign ram_we_s   = pop_accept_s && !rst;
    assign ram_widx_s = head_entry_s.idx[AW-1:0];

    // Byte-enabled write of the head entry into its RAM word
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            for (int b = 32'sd0; b < 32'sd4; b++) begin
                if (head_entry_s.mask[b]) begin
                    ram_r[ram_widx_s][b*BYTE_W +: BYTE_W] <= head_entry_s.data[b*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    assign read_idx_s     = read_addr[AW+1:2];
    assign read_idx_ext_s = IDX_W'(read_idx_s);

    // Overlay live entries oldest to newest so the youngest matching store owns each lane
    always_comb begin
        raw_s = ram_r[read_idx_s];
        for (int k = 32'sd0; k < DEPTH; k++) begin
            for (int b = 32'sd0; b < 32'sd4; b++) begin
                raw_s[b*BYTE_W +: BYTE_W] =
                    (ordered_valid_s[k] && (ordered_s[k].idx == read_idx_ext_s) && ordered_s[k].mask[b])
                    ? ordered_s[k].data[b*BYTE_W +: BYTE_W] : raw_s[b*BYTE_W +: BYTE_W];
            end
        end
        read_data_s = read_en ? load_extend(read_op, read_addr[1:0], raw_s) : 32'h0000_0000;
    end

    assign read_data = read_data_s;

    assign unused_s = ^{write_addr[31:AW+2], read_addr[31:AW+2], head_entry_s.idx[IDX_W-1:AW]};

`ifdef DMEM_PERF_EN
    logic [31:0] perf_stores_r;
    logic [31:0] perf_drain_stall_r;
    logic [PW:0] perf_max_occ_r;

    // Accepted-store count, load-blocked drain cycles and occupancy high-water mark
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stores_r      <= 32'h0000_0000;
            perf_drain_stall_r <= 32'h0000_0000;
            perf_max_occ_r     <= '0;
        end else begin
            if (push_accept_s) begin
                perf_stores_r <= perf_stores_r + 32'd1;
            end
            if (read_en && !sq_empty) begin
                perf_drain_stall_r <= perf_drain_stall_r + 32'd1;
            end
            if (sq_count > perf_max_occ_r) begin
                perf_max_occ_r <= sq_count;
            end
        end
    end

    assign perf_stores      = perf_stores_r;
    assign perf_drain_stall = perf_drain_stall_r;
    assign perf_max_occ     = perf_max_occ_r;
`endif

endmodule

// File: doc/dmem_store_responder.md
Name: dmem_store_responder

Overview:
- Data-memory responder serving the CPU core's data port (read and write channels).
- Writes (SB/SH/SW) arrive from the EX stage and are queued in a store queue. The queue drains one entry per cycle into a single-port word RAM.
- Reads (LB/LH/LW/LBU/LHU) arrive from the MEM stage and are answered combinationally. Pending queued stores are merged byte-wise into read data, so a load always sees every older store.
- Read has priority on the RAM port. The queue drains only on cycles with no read.

Parameters:
- DEPTH, 4: store-queue entries; power of two, at least 2.
- MEM_WORDS, 1024: RAM size in 32-bit words; power of two.
- Localparams AW = clog2(MEM_WORDS) and PW = clog2(DEPTH) are derived, not overridable.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset.
- write_en  in  1  store request, sampled at posedge.
- write_op  in  3  funct3: 000 SB, 001 SH, 010 SW.
- write_addr  in  32  byte address.
- write_data  in  32  store data, right-aligned.
- read_en  in  1  load request; combinational.
- read_op  in  3  funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- read_addr  in  32  byte address.
- read_data  out  32  extended load result; combinational.
- sq_full  out  1  queue holds DEPTH entries.
- sq_empty  out  1  queue holds 0 entries.
- sq_count  out  PW+1  occupancy.
- overflow_err  out  1  sticky; a store was dropped.

Interface decision: one clock; reset is asynchronous and active-high.

Behaviour:
- Reset values (asynchronous, active-high): head = 0, tail = 0, sq_count = 0, sq_full = 0, sq_empty = 1, overflow_err = 0. Queue contents are discarded. RAM is not reset; reads of never-written words are undefined.
- Word index is addr[AW+1:2]. Upper address bits are ignored, so addresses wrap modulo MEM_WORDS*4.
- Enqueue converts each store to {word index, 4-bit byte mask, lane-aligned data}:
  - SB: mask = 1<<addr[1:0]; data = {4{write_data[7:0]}}.
  - SH: mask = addr[1] ? 1100 : 0011; data = {2{write_data[15:0]}}. addr[0] is ignored.
  - SW: mask = 1111. addr[1:0] are ignored.
  - Any other write_op: no enqueue, no error.
- Drain: when read_en = 0 and the queue is not empty, at posedge the head entry's masked bytes are written into the RAM word and head advances.
- Count update per cycle:
  - Enqueue and drain in the same cycle: count unchanged; accepted even when full.
  - Enqueue while full with no drain: entry dropped, state unchanged, overflow_err set to 1 and held until reset.
- Read path (combinational, zero latency):
  - Raw word = RAM word, overlaid by every valid queue entry with a matching word index, oldest to newest, per byte lane under its mask. The newest store wins.
  - A store presented on write_en in the same cycle is not visible; it is younger than the load.
- Lane select and extension:
  - LB/LBU: byte addr[1:0].
  - LH/LHU: half addr[1]; addr[0] ignored.
  - LW: full word.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- read_data = 0 when read_en = 0 or read_op is invalid.
- Pointers wrap modulo DEPTH. sq_full and sq_empty are decoded from the count, so a full queue and an empty queue are never ambiguous.
- Reset mid-drain aborts the drain; a RAM write at the same edge as reset assertion must not occur.

Optional Feature:
- Macro: DMEM_PERF_EN.
- When defined, adds outputs perf_stores (32-bit, accepted enqueues), perf_drain_stall (32-bit, cycles with a non-empty queue and read_en = 1) and perf_max_occ (PW+1, high-water mark of sq_count). All reset to 0; the 32-bit counters wrap.
- When undefined, these ports and registers are absent and behaviour is otherwise identical.

Decomposition:
- Shared package dmem_pkg holds:
  - funct3 constants for SB/SH/SW/LB/LH/LW/LBU/LHU;
  - the store-entry typedef {idx, mask[3:0], data[31:0]};
  - functions store_mask(op, addr) and load_extend(op, addr, word).
- One natural sub-module, dmem_store_queue: FIFO storage plus pointers, count, full/empty, overflow flag, and a flat view of all entries for the merge.
- The top level holds the RAM, the byte-lane merge and the load extension.

Test Plan:
1. After reset, hold read_en = 1 with LW at 0x10; SW 0x11223344 at 0x10 → next cycle read_data = 0x11223344, sq_count = 1, sq_empty = 0.
2. Continue from 1 with read_en held; SB data 0x000000AA at 0x11 → LW at 0x10 = 0x1122AA44, LB at 0x11 = 0xFFFFFFAA, LBU at 0x11 = 0x000000AA, LH at 0x12 = 0x00001122.
3. DEPTH = 4, read_en held at 1, five consecutive SW → sq_full = 1 after the fourth, fifth dropped, overflow_err = 1, sq_count = 4.
4. From 3, drop read_en → sq_count falls 4, 3, 2, 1, 0 over four cycles, sq_empty = 1. A later LW returns the RAM values, and overflow_err stays 1.
5. Full queue with read_en = 0, SW issued → simultaneous drain and enqueue accepted, sq_count stays 4, overflow_err stays 0.
6. Assert rst while the queue holds 3 entries → sq_count = 0, sq_empty = 1, overflow_err = 0. Drained words are kept; undrained stores are absent from later LW.
